mem_request_arbiter: RTL and testbench
======================================

MEM_REQUEST_ARBITER -- requirements
Module: mem_request_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles spent in WAIT before a timeout is declared (range 2..255).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  reset, asynchronous and active-low.
REQ-004 if_req/if_addr[31:0]/if_virt  in  fetch client: request, byte address, address-is-virtual.
REQ-005 if_ack/if_err  out  1 each; if_rdata  out  32  fetch completion pulse, error flag, read data.
REQ-006 d_req/d_we/d_addr[31:0]/d_wdata[31:0]/d_virt  in  data client: request, write enable, address, write data, address-is-virtual.
REQ-007 d_ack/d_err  out  1 each; d_rdata  out  32  data completion pulse, error flag, read data.
REQ-008 exec_mode  in  1  core execution mode, latched at grant.
REQ-009 mcRamAddress/mcRamIn  out  32 each; mcReadReq/mcWriteReq/mcAddrVirtual/mcExecMode  out  1 each  memory-controller request.
REQ-010 mcRamOut  in  32; mcStatus  in  2  memory-controller read data and status (0 error, 1 busy, 2 done).
REQ-011 timeout  out  1  sticky flag: the controller failed to respond.

Function
REQ-012 States: IDLE, ISSUE, WAIT, RESP, HALT.
REQ-013 IDLE: if any req is high, grant one client, latch addr/wdata/virt/exec_mode/we into mc* outputs, then go to ISSUE; otherwise stay in IDLE.
REQ-014 Grant signals: fetch drives mcReadReq=1, mcWriteReq=0; data drives mcReadReq=!d_we, mcWriteReq=d_we.
REQ-015 ISSUE lasts exactly one cycle, with mcReadReq/mcWriteReq high; then deassert both, clear the timeout counter, and go to WAIT.
REQ-016 Requests are single-cycle pulses; mcReadReq/mcWriteReq are never high outside ISSUE.
REQ-017 WAIT samples mcStatus at every edge: 2 captures mcRamOut into the granted client's rdata (reads only), clears err, and goes to RESP; 0 sets err and goes to RESP; 1 increments the counter.
REQ-018 When the counter reaches TIMEOUT_CYCLES in WAIT: set timeout, pulse the granted ack with err=1, and go to HALT.
REQ-019 RESP: the granted client's ack is high for exactly one cycle, then the block returns to IDLE.
REQ-020 Clients hold req and payload stable until ack, and drop req in the cycle after ack; a req still high in IDLE starts a new transaction.
REQ-021 mcStatus is ignored outside WAIT, so a stale status of 2 or 0 during ISSUE has no effect.
REQ-022 rdata holds its value until the next completion for that client; write completions leave rdata unchanged.
REQ-023 Latency with a physical access and the controller's two-cycle path: req sampled at edge E0, ack high in the cycle after edge E4.
REQ-024 HALT: no further grants; acks stay low until reset.
REQ-025 Simultaneous if_req and d_req are resolved per REQ-029/REQ-030; the loser remains pending, and ack never goes to both clients in the same cycle.

Reset
REQ-026 On reset assertion, immediately: state=IDLE; all ack, err, mcReadReq, mcWriteReq, mcAddrVirtual, mcExecMode and timeout outputs at 0; all address, data and rdata outputs at 0; counter at 0; round-robin pointer at fetch.
REQ-027 Reset asserted mid-transaction abandons it with no ack; the controller is reset alongside.
REQ-028 On reset release, the first grant can occur at the first rising edge.

Configuration
REQ-029 ARB_ROUND_ROBIN_EN defined: round-robin arbitration; the pointer toggles to the other client after each grant, and the client the pointer names wins a tie.
REQ-030 ARB_ROUND_ROBIN_EN undefined: fixed priority; the data client always wins a tie.

Structure
REQ-031 Package mem_arb_pkg holds the state enum, the status constants MC_STAT_ERR=0, MC_STAT_BUSY=1, MC_STAT_DONE=2, and the client-id typedef.
REQ-032 Sub-module mem_arb_pick: combinational grant selection from the two reqs and the pointer, containing the ARB_ROUND_ROBIN_EN switch.

Verification
REQ-033 d_req read of 0x0000_1000, phys; mcStatus goes 1,1,2 with mcRamOut=0xDEAD_BEEF -> d_ack in the cycle after E4, d_rdata=0xDEAD_BEEF, d_err=0, mcReadReq high exactly one cycle.
REQ-034 if_req and d_req both high at 0x100/0x200, round-robin build -> fetch served first, then data; no-macro build -> data first.
REQ-035 d_req write 0x55AA_55AA to 0x40 -> mcWriteReq pulse, mcRamIn=0x55AA_55AA; after status 2, d_ack=1 and d_rdata unchanged.
REQ-036 Controller returns status 0 on a virtual fetch with exec_mode=1 -> if_ack=1, if_err=1, mcExecMode=1 during ISSUE.
REQ-037 mcStatus held at 1 with TIMEOUT_CYCLES=8 -> ack with err=1 after 8 WAIT cycles, timeout=1, a later d_req is not granted, reset clears timeout.
REQ-038 Reset asserted during WAIT -> no ack pulse, all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter: FSM states,
// memory-controller status codes and the client identifier.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_HALT  = 3'd4
  } arb_state_t;

  typedef enum logic {
    CLIENT_FETCH = 1'b0,
    CLIENT_DATA  = 1'b1
  } client_id_t;

  localparam logic [1:0] MC_STAT_ERR  = 2'd0;
  localparam logic [1:0] MC_STAT_BUSY = 2'd1;
  localparam logic [1:0] MC_STAT_DONE = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the fetch and data clients.
// ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise data has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_ifReq,
  input  logic       i_dReq,
  input  client_id_t i_ptr,
  output logic       o_valid,
  output client_id_t o_grant
);

`ifndef ARB_ROUND_ROBIN_EN
  logic w_unusedPtr;
  assign w_unusedPtr = i_ptr;
`endif

  always_comb begin
    o_valid = i_ifReq | i_dReq;
    o_grant = CLIENT_FETCH;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_ifReq && i_dReq) begin
      o_grant = i_ptr;
    end else if (i_dReq) begin
      o_grant = CLIENT_DATA;
    end
`else
    if (i_dReq) begin
      o_grant = CLIENT_DATA;
    end
`endif
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Arbitrates fetch and data clients onto a single memory-controller port.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default build gives data priority.
module mem_request_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_virt,
  output logic        if_ack,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_virt,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  input  logic        exec_mode,
  output logic [31:0] mcRamAddress,
  output logic [31:0] mcRamIn,
  output logic        mcReadReq,
  output logic        mcWriteReq,
  output logic        mcAddrVirtual,
  output logic        mcExecMode,
  input  logic [31:0] mcRamOut,
  input  logic [1:0]  mcStatus,
  output logic        timeout
);

  localparam logic [7:0] LP_LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t r_state;
  arb_state_t w_nextState;
  client_id_t r_owner;
  client_id_t r_ptr;
  client_id_t w_pickId;
  logic       w_pickValid;
  logic       w_grant;
  logic       w_complete;
  logic       w_fail;
  logic       w_expire;
  logic [7:0] r_count;
  logic       r_isWrite;
  logic [31:0] r_mcAddr;
  logic [31:0] r_mcWdata;
  logic       r_mcVirt;
  logic       r_mcExec;
  logic       r_ifAck;
  logic       r_ifErr;
  logic [31:0] r_ifRdata;
  logic       r_dAck;
  logic       r_dErr;
  logic [31:0] r_dRdata;
  logic       r_timeout;

  mem_arb_pick u_pick (
    .i_ifReq (if_req),
    .i_dReq  (d_req),
    .i_ptr   (r_ptr),
    .o_valid (w_pickValid),
    .o_grant (w_pickId)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_complete  = 1'b0;
    w_fail      = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pickValid) begin
          w_grant     = 1'b1;
          w_nextState = ST_ISSUE;
        end
      end
      ST_ISSUE: w_nextState = ST_WAIT;
      ST_WAIT: begin
        case (mcStatus)
          MC_STAT_DONE: begin
            w_complete  = 1'b1;
            w_nextState = ST_RESP;
          end
          MC_STAT_ERR: begin
            w_fail      = 1'b1;
            w_nextState = ST_RESP;
          end
          default: begin
            if (r_count == LP_LAST_COUNT) begin
              w_expire    = 1'b1;
              w_nextState = ST_HALT;
            end
          end
        endcase
      end
      ST_RESP: w_nextState = ST_IDLE;
      ST_HALT: w_nextState = ST_HALT;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Datapath: latch the winning request, run the wait counter, and post
  // one-cycle acks with error/read data when the controller finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner   <= CLIENT_FETCH;
      r_ptr     <= CLIENT_FETCH;
      r_count   <= '0;
      r_isWrite <= 1'b0;
      r_mcAddr  <= '0;
      r_mcWdata <= '0;
      r_mcVirt  <= 1'b0;
      r_mcExec  <= 1'b0;
      r_ifAck   <= 1'b0;
      r_ifErr   <= 1'b0;
      r_ifRdata <= '0;
      r_dAck    <= 1'b0;
      r_dErr    <= 1'b0;
      r_dRdata  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_ifAck <= 1'b0;
      r_dAck  <= 1'b0;
      if (w_grant) begin
        r_owner  <= w_pickId;
        r_ptr    <= (w_pickId == CLIENT_FETCH) ? CLIENT_DATA : CLIENT_FETCH;
        r_mcExec <= exec_mode;
        if (w_pickId == CLIENT_DATA) begin
          r_mcAddr  <= d_addr;
          r_mcWdata <= d_wdata;
          r_mcVirt  <= d_virt;
          r_isWrite <= d_we;
        end else begin
          r_mcAddr  <= if_addr;
          r_mcWdata <= '0;
          r_mcVirt  <= if_virt;
          r_isWrite <= 1'b0;
        end
      end
      if (r_state == ST_ISSUE) begin
        r_count <= '0;
      end else if (r_state == ST_WAIT && !w_complete && !w_fail && !w_expire) begin
        r_count <= r_count + 8'd1;
      end
      if (w_complete || w_fail || w_expire) begin
        if (r_owner == CLIENT_DATA) begin
          r_dAck <= 1'b1;
          r_dErr <= w_fail | w_expire;
          if (w_complete && !r_isWrite) begin
            r_dRdata <= mcRamOut;
          end
        end else begin
          r_ifAck <= 1'b1;
          r_ifErr <= w_fail | w_expire;
          if (w_complete && !r_isWrite) begin
            r_ifRdata <= mcRamOut;
          end
        end
      end
      if (w_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign mcReadReq     = (r_state == ST_ISSUE) && !r_isWrite;
  assign mcWriteReq    = (r_state == ST_ISSUE) &&  r_isWrite;
  assign mcRamAddress  = r_mcAddr;
  assign mcRamIn       = r_mcWdata;
  assign mcAddrVirtual = r_mcVirt;
  assign mcExecMode    = r_mcExec;
  assign if_ack        = r_ifAck;
  assign if_err        = r_ifErr;
  assign if_rdata      = r_ifRdata;
  assign d_ack         = r_dAck;
  assign d_err         = r_dErr;
  assign d_rdata       = r_dRdata;
  assign timeout       = r_timeout;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Randomized self-checking bench for mem_request_arbiter; the bench plays the
// memory controller and predicts each transaction from a transaction-level model.
module tb_mem_request_arbiter;

  localparam int TO_CYCLES = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_virt, d_req, d_we, d_virt, exec_mode;
  logic [31:0] if_addr, d_addr, d_wdata, mcRamOut;
  logic [1:0]  mcStatus;
  logic        if_ack, if_err, d_ack, d_err;
  logic [31:0] if_rdata, d_rdata, mcRamAddress, mcRamIn;
  logic        mcReadReq, mcWriteReq, mcAddrVirtual, mcExecMode, timeout;

  int nChecks = 0;
  int nPass   = 0;

  // model state: which client wins the next tie, last read data and error per client
  bit          mPtrData;
  logic [31:0] mIfRdata, mDRdata;
  bit          mIfErr, mDErr;

  mem_request_arbiter #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_virt(if_virt),
    .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_virt(d_virt),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .exec_mode(exec_mode),
    .mcRamAddress(mcRamAddress), .mcRamIn(mcRamIn),
    .mcReadReq(mcReadReq), .mcWriteReq(mcWriteReq),
    .mcAddrVirtual(mcAddrVirtual), .mcExecMode(mcExecMode),
    .mcRamOut(mcRamOut), .mcStatus(mcStatus), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed === expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit modelWinner(input bit ifr, input bit dr);
    if (ifr && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
      return mPtrData;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  task automatic modelReset();
    mPtrData = 1'b0;
    mIfRdata = '0;
    mDRdata  = '0;
    mIfErr   = 1'b0;
    mDErr    = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ifAck"}, if_ack, 0);
    checkOutput({tag, "_dAck"}, d_ack, 0);
    checkOutput({tag, "_rd"}, mcReadReq, 0);
    checkOutput({tag, "_wr"}, mcWriteReq, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkIdleOutputs(tag);
    checkOutput({tag, "_ifErr"}, if_err, 0);
    checkOutput({tag, "_dErr"}, d_err, 0);
    checkOutput({tag, "_ifRdata"}, if_rdata, 0);
    checkOutput({tag, "_dRdata"}, d_rdata, 0);
    checkOutput({tag, "_addr"}, mcRamAddress, 0);
    checkOutput({tag, "_in"}, mcRamIn, 0);
    checkOutput({tag, "_virt"}, mcAddrVirtual, 0);
    checkOutput({tag, "_exec"}, mcExecMode, 0);
    checkOutput({tag, "_timeout"}, timeout, 0);
  endtask

  // Called #1 after an edge with the client's request already driven and
  // guaranteed to win at the next edge; returns #1 after the edge back to IDLE.
  task automatic applyStimulus(input bit cData, input int nBusy,
                               input logic [1:0] finalStat, input logic [31:0] ramOut);
    logic [31:0] expAddr, expIn;
    logic        expWe, expVirt, expExec;
    if (cData) begin
      expAddr = d_addr;  expIn = d_wdata; expWe = d_we;  expVirt = d_virt;
    end else begin
      expAddr = if_addr; expIn = '0;      expWe = 1'b0;  expVirt = if_virt;
    end
    expExec  = exec_mode;
    mcStatus = 2'($urandom_range(0, 2));
    tick();
    checkOutput("issueRd", mcReadReq, !expWe);
    checkOutput("issueWr", mcWriteReq, expWe);
    checkOutput("issueAddr", mcRamAddress, expAddr);
    checkOutput("issueIn", mcRamIn, expIn);
    checkOutput("issueVirt", mcAddrVirtual, expVirt);
    checkOutput("issueExec", mcExecMode, expExec);
    mcStatus = $urandom_range(0, 1) ? 2'd2 : 2'd0;
    tick();
    checkIdleOutputs("waitEntry");
    for (int i = 0; i < nBusy; i++) begin
      mcStatus = 2'd1;
      tick();
      checkOutput("waitIfAck", if_ack, 0);
      checkOutput("waitDAck", d_ack, 0);
    end
    mcStatus = finalStat;
    mcRamOut = ramOut;
    tick();
    if (cData) begin
      mDErr = (finalStat == 2'd0);
      if (finalStat == 2'd2 && !expWe) mDRdata = ramOut;
    end else begin
      mIfErr = (finalStat == 2'd0);
      if (finalStat == 2'd2) mIfRdata = ramOut;
    end
    mPtrData = !cData;
    checkOutput("ackIf", if_ack, !cData);
    checkOutput("ackD", d_ack, cData);
    checkOutput("errIf", if_err, mIfErr);
    checkOutput("errD", d_err, mDErr);
    checkOutput("rdataIf", if_rdata, mIfRdata);
    checkOutput("rdataD", d_rdata, mDRdata);
    if (cData) d_req = 1'b0; else if_req = 1'b0;
    mcStatus = 2'($urandom_range(0, 2));
    mcRamOut = $urandom;
    tick();
    checkOutput("respEndIf", if_ack, 0);
    checkOutput("respEndD", d_ack, 0);
  endtask

  initial begin
    reset = 1'b0;
    if_req = 0; if_virt = 0; d_req = 0; d_we = 0; d_virt = 0; exec_mode = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mcRamOut = '0; mcStatus = 2'd1;
    modelReset();
    #3;
    checkAllZero("reset");
    tick();
    tick();

    // Read at 0x1000 requested while reset releases: first edge grants it.
    d_req = 1; d_we = 0; d_addr = 32'h0000_1000; d_virt = 0; exec_mode = 0;
    reset = 1'b1;
    applyStimulus(1'b1, 2, 2'd2, 32'hDEAD_BEEF);

    // Simultaneous fetch at 0x100 and data at 0x200.
    if_req = 1; if_addr = 32'h100; if_virt = 0;
    d_req = 1; d_addr = 32'h200; d_we = 0; d_virt = 0;
    begin
      bit first;
      first = modelWinner(1'b1, 1'b1);
      checkOutput("tieWinnerPtr", {31'd0, first},
`ifdef ARB_ROUND_ROBIN_EN
                  32'd0
`else
                  32'd1
`endif
      );
      applyStimulus(first, 1, 2'd2, 32'h1111_2222);
      applyStimulus(!first, 0, 2'd2, 32'h3333_4444);
    end

    // Write 0x55AA55AA to 0x40 leaves d_rdata untouched.
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h55AA_55AA; d_virt = 0;
    applyStimulus(1'b1, 1, 2'd2, 32'hBAD0_BAD0);
    d_we = 0;

    // Virtual fetch in exec mode 1, controller reports an error.
    if_req = 1; if_addr = 32'h8000_0000; if_virt = 1; exec_mode = 1;
    applyStimulus(1'b0, 0, 2'd0, 32'h0);
    exec_mode = 0;

    for (int n = 0; n < 30; n++) begin
      int pat;
      bit w;
      pat = $urandom_range(0, 2);
      if_addr = $urandom; if_virt = 1'($urandom);
      d_addr = $urandom;  d_wdata = $urandom; d_we = 1'($urandom); d_virt = 1'($urandom);
      exec_mode = 1'($urandom);
      if_req = (pat != 1);
      d_req  = (pat != 0);
      w = modelWinner(if_req, d_req);
      applyStimulus(w, $urandom_range(0, 3), $urandom_range(0, 3) == 0 ? 2'd0 : 2'd2, $urandom);
      if (pat == 2) begin
        applyStimulus(!w, $urandom_range(0, 3), $urandom_range(0, 3) == 0 ? 2'd0 : 2'd2, $urandom);
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        checkIdleOutputs("gap");
      end
    end

    // Reset asserted in the middle of WAIT abandons the transaction.
    d_req = 1; d_we = 0; d_addr = 32'hCAFE_0000; mcStatus = 2'd1;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b0;
    d_req = 1'b0;
    #1;
    modelReset();
    checkAllZero("midWaitReset");
    tick();
    tick();
    checkOutput("midWaitNoAck", d_ack, 0);
    reset = 1'b1;
    tick();

    // Controller stuck busy: timeout after TO_CYCLES WAIT cycles, then halt.
    if_req = 1; if_addr = 32'h2000; if_virt = 0; mcStatus = 2'd1;
    tick();
    checkOutput("toIssue", mcReadReq, 1);
    tick();
    for (int i = 1; i < TO_CYCLES; i++) begin
      tick();
      checkOutput("toWaitAck", if_ack, 0);
      checkOutput("toWaitFlag", timeout, 0);
    end
    tick();
    checkOutput("toAck", if_ack, 1);
    checkOutput("toErr", if_err, 1);
    checkOutput("toFlag", timeout, 1);
    if_req = 0;
    tick();
    checkOutput("toAckDrop", if_ack, 0);
    checkOutput("toSticky", timeout, 1);
    d_req = 1; d_we = 0; mcStatus = 2'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("haltRd", mcReadReq, 0);
      checkOutput("haltAck", d_ack, 0);
    end
    #2;
    reset = 1'b0;
    d_req = 1'b0;
    #1;
    checkOutput("toCleared", timeout, 0);
    tick();
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
